terminal_ram_arbiter: RTL and testbench

//  Two-master arbiter for the 64-bit x 8192-word single-port on-chip RAM.

---
 rtl/terminal_ram_arbiter.sv | 110 +++++++++++
 tb/tb_terminal_ram_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/terminal_ram_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM.
// Combinational grant (round-robin or fixed priority) with an id-tagged read-return pipeline.
module terminal_ram_arbiter #(
   parameter int ADDR_W      = 13,
   parameter int DATA_W      = 64,
   parameter int BE_W        = 8,
   parameter int RAM_LATENCY = 1,
   parameter int FIXED_PRIO  = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_waitrequest,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_waitrequest,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] ram_address,
   output logic [BE_W-1:0]   ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_writedata,
   output logic              ram_clken,
   input  logic [DATA_W-1:0] ram_readdata
);

   logic                   r_ready;
   logic                   r_last_grant;
   logic [RAM_LATENCY-1:0] r_pipe_valid;
   logic [RAM_LATENCY-1:0] r_pipe_id;

   logic w_req0;
   logic w_req1;
   logic w_gnt0;
   logic w_gnt1;
   logic w_rd_accept;

   assign w_req0 = m0_read | m0_write;
   assign w_req1 = m1_read | m1_write;

   // r_last_grant=1 means master 1 won last, so master 0 wins the next contest.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (r_ready) begin
         if (w_req0 && w_req1) begin
            if ((FIXED_PRIO != 0) || r_last_grant)
               w_gnt0 = 1'b1;
            else
               w_gnt1 = 1'b1;
         end else begin
            w_gnt0 = w_req0;
            w_gnt1 = w_req1;
         end
      end
   end

   assign w_rd_accept = (w_gnt0 & m0_read & ~m0_write) | (w_gnt1 & m1_read & ~m1_write);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ready      <= 1'b0;
         r_last_grant <= 1'b1;
      end else begin
         r_ready <= 1'b1;
         if (w_gnt0 || w_gnt1)
            r_last_grant <= w_gnt1;
      end
   end

   // Reset drops any reads still in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pipe_valid <= '0;
         r_pipe_id    <= '0;
      end else begin
         r_pipe_valid[0] <= w_rd_accept;
         r_pipe_id[0]    <= w_gnt1;
         for (int i = 1; i < RAM_LATENCY; i++) begin
            r_pipe_valid[i] <= r_pipe_valid[i-1];
            r_pipe_id[i]    <= r_pipe_id[i-1];
         end
      end
   end

   assign m0_waitrequest   = ~w_gnt0;
   assign m1_waitrequest   = ~w_gnt1;
   assign m0_readdatavalid = r_pipe_valid[RAM_LATENCY-1] & ~r_pipe_id[RAM_LATENCY-1];
   assign m1_readdatavalid = r_pipe_valid[RAM_LATENCY-1] &  r_pipe_id[RAM_LATENCY-1];
   assign m0_readdata      = ram_readdata;
   assign m1_readdata      = ram_readdata;

   assign ram_chipselect = w_gnt0 | w_gnt1;
   assign ram_write      = w_gnt1 ? m1_write      : (w_gnt0 & m0_write);
   assign ram_address    = w_gnt1 ? m1_address    : m0_address;
   assign ram_byteenable = w_gnt1 ? m1_byteenable : m0_byteenable;
   assign ram_writedata  = w_gnt1 ? m1_writedata  : m0_writedata;
   assign ram_clken      = 1'b1;

endmodule

// File: tb/tb_terminal_ram_arbiter.sv
// Bench for terminal_ram_arbiter: RAM model behind the round-robin instance, a fixed-priority
// twin driven by the same masters, and a transaction-level reference model checked every cycle.
module tb_terminal_ram_arbiter;

   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [12:0] m0_address, m1_address;
   logic [7:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [63:0] m0_writedata, m1_writedata;
   logic [63:0] m0_readdata, m1_readdata;
   logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic [12:0] ram_address;
   logic [7:0]  ram_byteenable;
   logic        ram_chipselect, ram_write, ram_clken;
   logic [63:0] ram_writedata, ram_readdata;

   logic [63:0] fp_m0_readdata, fp_m1_readdata;
   logic        fp_m0_waitrequest, fp_m1_waitrequest, fp_m0_readdatavalid, fp_m1_readdatavalid;
   logic [12:0] fp_ram_address;
   logic [7:0]  fp_ram_byteenable;
   logic        fp_ram_chipselect, fp_ram_write, fp_ram_clken;
   logic [63:0] fp_ram_writedata;
   logic [63:0] fp_ram_readdata;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;
   assign fp_ram_readdata = '0;

   terminal_ram_arbiter #(.ADDR_W(13), .DATA_W(64), .BE_W(8), .RAM_LATENCY(LAT), .FIXED_PRIO(0)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
      .m1_readdatavalid(m1_readdatavalid),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
      .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_clken(ram_clken),
      .ram_readdata(ram_readdata)
   );

   terminal_ram_arbiter #(.ADDR_W(13), .DATA_W(64), .BE_W(8), .RAM_LATENCY(LAT), .FIXED_PRIO(1)) dut_fp (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_readdata(fp_m0_readdata), .m0_waitrequest(fp_m0_waitrequest),
      .m0_readdatavalid(fp_m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_readdata(fp_m1_readdata), .m1_waitrequest(fp_m1_waitrequest),
      .m1_readdatavalid(fp_m1_readdatavalid),
      .ram_address(fp_ram_address), .ram_byteenable(fp_ram_byteenable),
      .ram_chipselect(fp_ram_chipselect), .ram_write(fp_ram_write), .ram_writedata(fp_ram_writedata),
      .ram_clken(fp_ram_clken), .ram_readdata(fp_ram_readdata)
   );

   // Simple single-port RAM with LAT-cycle registered read.
   bit   [63:0] ram_mem [0:8191];
   logic [63:0] rd_pipe [0:LAT-1];

   always @(posedge clk) begin
      if (ram_chipselect) begin
         if (ram_write) begin
            for (int b = 0; b < 8; b++)
               if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
         end else begin
            rd_pipe[0] <= ram_mem[ram_address];
         end
      end
      for (int s = 1; s < LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
   end
   assign ram_readdata = rd_pipe[LAT-1];

   // Reference model: memory image, last winner, readiness and expected returns.
   typedef struct {
      int          due;
      int          id;
      logic [63:0] data;
   } ret_t;

   bit [63:0] model_mem [0:8191];
   int        last_winner = 1;
   bit        model_ready = 1'b0;
   ret_t      ret_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
   endtask

   task automatic step(input bit r0, input bit w0, input logic [12:0] a0, input logic [63:0] d0,
                       input logic [7:0] be0, input bit r1, input bit w1, input logic [12:0] a1,
                       input logic [63:0] d1, input logic [7:0] be1);
      bit          q0, q1, e_rdv0, e_rdv1, is_wr, rst_at_edge;
      int          g, gfp;
      logic [63:0] e_data, wd;
      logic [12:0] wa;
      logic [7:0]  wbe;
      ret_t        r;
      m0_read = r0; m0_write = w0; m0_address = a0; m0_writedata = d0; m0_byteenable = be0;
      m1_read = r1; m1_write = w1; m1_address = a1; m1_writedata = d1; m1_byteenable = be1;
      #1;
      if (!reset_n) begin
         model_ready = 1'b0;
         last_winner = 1;
         ret_q.delete();
      end
      q0 = r0 | w0;
      q1 = r1 | w1;
      g = -1;
      gfp = -1;
      if (reset_n && model_ready) begin
         if (q0 && q1) g = (last_winner == 0) ? 1 : 0;
         else if (q0)  g = 0;
         else if (q1)  g = 1;
         gfp = q0 ? 0 : (q1 ? 1 : -1);
      end
      e_rdv0 = 1'b0;
      e_rdv1 = 1'b0;
      e_data = '0;
      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
         r = ret_q.pop_front();
         e_data = r.data;
         if (r.id == 0) e_rdv0 = 1'b1; else e_rdv1 = 1'b1;
      end
      is_wr = (g == 0) ? w0 : w1;
      wa    = (g == 1) ? a1 : a0;
      wd    = (g == 1) ? d1 : d0;
      wbe   = (g == 1) ? be1 : be0;

      chk("m0_waitrequest", m0_waitrequest, g != 0);
      chk("m1_waitrequest", m1_waitrequest, g != 1);
      chk("fp_m0_waitrequest", fp_m0_waitrequest, gfp != 0);
      chk("fp_m1_waitrequest", fp_m1_waitrequest, gfp != 1);
      chk("fp_ram_chipselect", fp_ram_chipselect, gfp >= 0);
      chk("m0_readdatavalid", m0_readdatavalid, e_rdv0);
      chk("m1_readdatavalid", m1_readdatavalid, e_rdv1);
      chk("ram_chipselect", ram_chipselect, g >= 0);
      chk("ram_write", ram_write, (g >= 0) && is_wr);
      if (e_rdv0) chk("m0_readdata", m0_readdata, e_data);
      if (e_rdv1) chk("m1_readdata", m1_readdata, e_data);
      if (g >= 0) chk("ram_address", ram_address, wa);

      if (g >= 0) begin
         last_winner = g;
         if (is_wr) begin
            for (int b = 0; b < 8; b++)
               if (wbe[b]) model_mem[wa][8*b +: 8] = wd[8*b +: 8];
         end else begin
            r.due  = cyc + LAT;
            r.id   = g;
            r.data = model_mem[wa];
            ret_q.push_back(r);
         end
      end
      rst_at_edge = ~reset_n;
      @(posedge clk);
      model_ready = ~rst_at_edge;
      #1;
      cyc++;
   endtask

   task automatic idle();
      step(0, 0, 13'h0, 64'h0, 8'h0, 0, 0, 13'h0, 64'h0, 8'h0);
   endtask

   initial begin
      bit          rr0, ww0, rr1, ww1;
      logic [12:0] aa0, aa1;
      reset_n = 1'b0;
      idle();
      idle();
      reset_n = 1'b1;
      idle();

      // m0 write then read back with no wait.
      step(0, 1, 13'h0010, 64'h0123456789ABCDEF, 8'hFF, 0, 0, 13'h0, 64'h0, 8'h0);
      step(1, 0, 13'h0010, 64'h0, 8'hFF, 0, 0, 13'h0, 64'h0, 8'h0);
      chk("t1_rdv", m0_readdatavalid, 1'b1);
      chk("t1_data", m0_readdata, 64'h0123456789ABCDEF);
      idle();
      step(0, 1, 13'h0001, 64'h1111_2222_3333_4444, 8'hFF, 0, 0, 13'h0, 64'h0, 8'h0);
      step(0, 0, 13'h0, 64'h0, 8'h0, 0, 1, 13'h0002, 64'h5555_6666_7777_8888, 8'hFF);

      // Both masters reading for 8 cycles: grants alternate.
      for (int i = 0; i < 8; i++)
         step(1, 0, 13'h0010, 64'h0, 8'hFF, 1, 0, 13'h0002, 64'h0, 8'hFF);
      idle();

      // Top address with partial byte enable.
      step(0, 1, 13'h1FFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 13'h0, 64'h0, 8'h0);
      step(0, 1, 13'h1FFF, 64'h0, 8'h0F, 0, 0, 13'h0, 64'h0, 8'h0);
      step(1, 0, 13'h1FFF, 64'h0, 8'hFF, 0, 0, 13'h0, 64'h0, 8'h0);
      chk("t4_rdv", m0_readdatavalid, 1'b1);
      chk("t4_data", m0_readdata, 64'hFFFF_FFFF_0000_0000);
      idle();

      // Fixed-priority twin: m0 holds 5 cycles, then drops.
      for (int i = 0; i < 5; i++)
         step(1, 0, 13'h0001, 64'h0, 8'hFF, 1, 0, 13'h0002, 64'h0, 8'hFF);
      step(0, 0, 13'h0, 64'h0, 8'h0, 1, 0, 13'h0002, 64'h0, 8'hFF);
      idle();

      // Reset right after an m1 read is accepted: the return is dropped.
      step(0, 0, 13'h0, 64'h0, 8'h0, 1, 0, 13'h0010, 64'h0, 8'hFF);
      reset_n = 1'b0;
      idle();
      step(1, 0, 13'h0001, 64'h0, 8'hFF, 1, 0, 13'h0002, 64'h0, 8'hFF);
      reset_n = 1'b1;
      step(1, 0, 13'h0001, 64'h0, 8'hFF, 1, 0, 13'h0002, 64'h0, 8'hFF);
      step(1, 0, 13'h0001, 64'h0, 8'hFF, 1, 0, 13'h0002, 64'h0, 8'hFF);
      chk("t5_m0_valid", m0_readdatavalid, 1'b1);
      chk("t5_m0_data", m0_readdata, 64'h1111_2222_3333_4444);
      step(0, 0, 13'h0, 64'h0, 8'h0, 1, 0, 13'h0002, 64'h0, 8'hFF);
      chk("t5_m1_valid", m1_readdatavalid, 1'b1);
      chk("t5_m1_data", m1_readdata, 64'h5555_6666_7777_8888);
      idle();

      // Randomized traffic over a small address set plus the top word.
      for (int i = 0; i < 400; i++) begin
         rr0 = ($urandom_range(0, 2) == 0);
         ww0 = ($urandom_range(0, 3) == 0);
         rr1 = ($urandom_range(0, 2) == 0);
         ww1 = ($urandom_range(0, 3) == 0);
         aa0 = ($urandom_range(0, 8) == 8) ? 13'h1FFF : 13'($urandom_range(0, 7));
         aa1 = ($urandom_range(0, 8) == 8) ? 13'h1FFF : 13'($urandom_range(0, 7));
         step(rr0, ww0, aa0, {$urandom, $urandom}, 8'($urandom),
              rr1, ww1, aa1, {$urandom, $urandom}, 8'($urandom));
      end
      idle();
      idle();
      chk("final_queue_empty", 64'(ret_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
